half_adder: RTL and testbench

Bit-parallel half adder: for every lane, computes sum = a XOR b and carry = a AND b combinationally, and also registers the results behind a valid flag. The combinational path is the primitive for ripple structures, e.g. a full adder built from two half adders plus an OR gate. The registered path, with its valid flag and carry-event counter, serves pipelined datapaths and bring-up monitoring. One clock domain.

---
 rtl/half_adder.sv | 44 ++++
 tb/tb_half_adder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/half_adder.sv
// half_adder: per-lane combinational sum/carry plus registered copy with valid flag and saturating carry-event counter
module half_adder #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  input  logic             cnt_clr,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry,
  output logic [WIDTH-1:0] sum_q,
  output logic [WIDTH-1:0] carry_q,
  output logic             out_valid,
  output logic [CNT_W-1:0] carry_cnt
);
  logic [WIDTH-1:0] sum_d, carry_d;
  logic [CNT_W-1:0] cnt_d;
  assign sum   = a ^ b;
  assign carry = a & b;
  always_comb begin
    sum_d   = in_valid ? sum : sum_q;
    carry_d = in_valid ? carry : carry_q;
    // clear wins over increment; all-ones counter holds instead of wrapping
    cnt_d   = cnt_clr ? '0
            : (in_valid && |carry && !(&carry_cnt)) ? carry_cnt + CNT_W'(1)
            : carry_cnt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q     <= '0;
      carry_q   <= '0;
      out_valid <= 1'b0;
      carry_cnt <= '0;
    end else begin
      sum_q     <= sum_d;
      carry_q   <= carry_d;
      out_valid <= in_valid;
      carry_cnt <= cnt_d;
    end
  end
endmodule

// File: tb/tb_half_adder.sv
// tb_half_adder: scoreboard bench for half_adder (4 lanes, 2-bit counter) plus 1-lane instances forming a full adder
module tb_half_adder;
  localparam int W = 4;
  localparam int CW = 2;
  localparam int CMAX = 3;
  typedef struct packed {
    logic [W-1:0]  s;
    logic [W-1:0]  c;
    logic          v;
    logic [CW-1:0] n;
  } exp_t;
  logic clk = 1'b0;
  logic rst, in_valid, cnt_clr;
  logic [W-1:0] a, b, sum, carry, sum_q, carry_q;
  logic out_valid;
  logic [CW-1:0] carry_cnt;
  logic fa_a, fa_b, fa_cin, s1, c1, s2, c2;
  logic [0:0] u1_sq, u1_cq, u2_sq, u2_cq;
  logic u1_ov, u2_ov;
  logic [15:0] u1_cnt, u2_cnt;
  exp_t q[$];
  exp_t e;
  logic [W-1:0] ms, mc;
  logic mv;
  int mn;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  half_adder #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(in_valid), .cnt_clr(cnt_clr),
    .sum(sum), .carry(carry), .sum_q(sum_q), .carry_q(carry_q),
    .out_valid(out_valid), .carry_cnt(carry_cnt)
  );
  half_adder ha1 (
    .clk(clk), .rst(rst), .a(fa_a), .b(fa_b), .in_valid(1'b0), .cnt_clr(1'b0),
    .sum(s1), .carry(c1), .sum_q(u1_sq), .carry_q(u1_cq),
    .out_valid(u1_ov), .carry_cnt(u1_cnt)
  );
  half_adder ha2 (
    .clk(clk), .rst(rst), .a(s1), .b(fa_cin), .in_valid(1'b0), .cnt_clr(1'b0),
    .sum(s2), .carry(c2), .sum_q(u2_sq), .carry_q(u2_cq),
    .out_valid(u2_ov), .carry_cnt(u2_cnt)
  );
  task automatic drive(input logic r, input logic iv, input logic cc,
                       input logic [W-1:0] aa, input logic [W-1:0] bb);
    exp_t x;
    rst = r; in_valid = iv; cnt_clr = cc; a = aa; b = bb;
    if (r) begin
      ms = '0; mc = '0; mv = 1'b0; mn = 0;
    end else begin
      if (iv) begin
        ms = aa ^ bb;
        mc = aa & bb;
      end
      mv = iv;
      if (cc) mn = 0;
      else if (iv && (aa & bb) != 0 && mn < CMAX) mn = mn + 1;
    end
    x.s = ms; x.c = mc; x.v = mv; x.n = CW'(mn);
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask
  task automatic test_comb();
    logic [1:0] tbl[4] = '{2'b00, 2'b10, 2'b10, 2'b01};
    for (int i = 0; i < 4; i++) begin
      {fa_a, fa_b} = 2'(i);
      rst = i[0];
      #1;
      checks++;
      if ({s1, c1} !== tbl[i]) begin
        errors++;
        $display("FAIL comb ab=%0d got sum,carry=%b%b want %b", i, s1, c1, tbl[i]);
      end
    end
  endtask
  task automatic test_full_adder();
    logic [1:0] tbl[8] = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b11};
    for (int i = 0; i < 8; i++) begin
      {fa_a, fa_b, fa_cin} = 3'(i);
      #1;
      checks++;
      if ({s2, c1 | c2} !== tbl[i]) begin
        errors++;
        $display("FAIL full_adder abc=%0d got sum,cout=%b%b want %b", i, s2, c1 | c2, tbl[i]);
      end
    end
  endtask
  task automatic test_reset();
    drive(1'b1, 1'b1, 1'b0, 4'hF, 4'hF);
    drive(1'b1, 1'b0, 1'b0, 4'h3, 4'h1);
    repeat (2) begin
      e = q.pop_front();
      checks++;
      if ({sum_q, carry_q, out_valid, carry_cnt} !== e || e !== '0) begin
        errors++;
        $display("FAIL reset got %h want 0", {sum_q, carry_q, out_valid, carry_cnt});
      end
    end
  endtask
  task automatic test_registered();
    drive(1'b0, 1'b1, 1'b0, 4'b1100, 4'b1010);
    e = q.pop_front();
    checks++;
    if ({sum_q, carry_q, out_valid} !== {4'b0110, 4'b1000, 1'b1} ||
        {sum_q, carry_q, out_valid, carry_cnt} !== e) begin
      errors++;
      $display("FAIL registered got sq=%b cq=%b v=%b n=%0d want sq=0110 cq=1000 v=1 n=%0d",
               sum_q, carry_q, out_valid, carry_cnt, e.n);
    end
    drive(1'b0, 1'b0, 1'b0, 4'b0101, 4'b0111);
    e = q.pop_front();
    checks++;
    if ({sum_q, carry_q, out_valid} !== {4'b0110, 4'b1000, 1'b0} ||
        {sum_q, carry_q, out_valid, carry_cnt} !== e) begin
      errors++;
      $display("FAIL hold got sq=%b cq=%b v=%b want sq=0110 cq=1000 v=0", sum_q, carry_q, out_valid);
    end
  endtask
  task automatic test_saturation();
    logic [CW-1:0] want[5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    drive(1'b0, 1'b0, 1'b1, 4'h0, 4'h0);
    e = q.pop_front();
    checks++;
    if (carry_cnt !== 2'd0 || {sum_q, carry_q, out_valid, carry_cnt} !== e) begin
      errors++;
      $display("FAIL clear got cnt=%0d want 0", carry_cnt);
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 1'b0, 4'b0001, 4'b0001);
      e = q.pop_front();
      checks++;
      if (carry_cnt !== want[i] || {sum_q, carry_q, out_valid, carry_cnt} !== e) begin
        errors++;
        $display("FAIL saturate step %0d got cnt=%0d want %0d", i, carry_cnt, want[i]);
      end
    end
    drive(1'b0, 1'b1, 1'b1, 4'hF, 4'hF);
    e = q.pop_front();
    checks++;
    if (carry_cnt !== 2'd0 || {sum_q, carry_q, out_valid, carry_cnt} !== e) begin
      errors++;
      $display("FAIL clear_priority got cnt=%0d want 0", carry_cnt);
    end
  endtask
  task automatic test_reset_mid();
    drive(1'b0, 1'b1, 1'b0, 4'hF, 4'hF);
    drive(1'b0, 1'b1, 1'b0, 4'h2, 4'h2);
    void'(q.pop_front());
    e = q.pop_front();
    checks++;
    if (carry_cnt !== 2'd2 || out_valid !== 1'b1 || {sum_q, carry_q, out_valid, carry_cnt} !== e) begin
      errors++;
      $display("FAIL pre_reset got cnt=%0d v=%b want cnt=2 v=1", carry_cnt, out_valid);
    end
    drive(1'b1, 1'b1, 1'b0, 4'hF, 4'hF);
    e = q.pop_front();
    checks++;
    if ({sum_q, carry_q, out_valid, carry_cnt} !== '0 || e !== '0) begin
      errors++;
      $display("FAIL mid_reset got %h want 0", {sum_q, carry_q, out_valid, carry_cnt});
    end
    checks++;
    if (carry !== 4'hF) begin
      errors++;
      $display("FAIL comb_during_reset got carry=%b want 1111", carry);
    end
    drive(1'b0, 1'b1, 1'b0, 4'h1, 4'h3);
    e = q.pop_front();
    checks++;
    if (out_valid !== 1'b1 || {sum_q, carry_q, out_valid, carry_cnt} !== e) begin
      errors++;
      $display("FAIL first_after_reset got %h want %h", {sum_q, carry_q, out_valid, carry_cnt}, e);
    end
  endtask
  task automatic test_random();
    logic [W-1:0] ra, rb;
    for (int i = 0; i < 10000; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      drive($urandom_range(0, 99) == 0, 1'($urandom), $urandom_range(0, 15) == 0, ra, rb);
      e = q.pop_front();
      checks++;
      if ({sum_q, carry_q, out_valid, carry_cnt} !== e) begin
        errors++;
        $display("FAIL random %0d got %h want %h", i, {sum_q, carry_q, out_valid, carry_cnt}, e);
      end
      checks++;
      if (sum !== (ra ^ rb) || carry !== (ra & rb) || (sum & carry) !== '0) begin
        errors++;
        $display("FAIL random_comb %0d got s=%b c=%b want s=%b c=%b", i, sum, carry, ra ^ rb, ra & rb);
      end
    end
  endtask
  initial begin
    rst = 1'b0; in_valid = 1'b0; cnt_clr = 1'b0; a = '0; b = '0;
    fa_a = 1'b0; fa_b = 1'b0; fa_cin = 1'b0;
    test_comb();
    test_full_adder();
    test_reset();
    test_registered();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
